issue_ctrl: RTL and testbench

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl.sv | 134 +++++++++++++
 tb/tb_issue_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_ctrl.sv
// Issue controller: register scoreboard for long-latency ops, RAW/WAW and
// capacity stalls, and the FENCE.I drain/flush handshake.
//
// Handshakes: ex_valid/ex_ready is a valid/ready pair. An instruction issues
// in the cycle both are high. id_ready tells the decoder that its current
// instruction was consumed this cycle. That is an issue for normal ops, or the
// flush_ack cycle for FENCE.I. Neither ex_valid nor id_ready waits on the
// other side's register state beyond the registered scoreboard.
module issue_ctrl #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_long,
  input  logic        id_flush,
  output logic        ex_valid,
  input  logic        ex_ready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic        flush_req,
  input  logic        flush_ack,
  output logic [31:0] pending,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_REQ   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   pending_q, pending_d;
  logic [CW-1:0] count_q, count_d;
  logic          flush_req_q, flush_req_d;

  logic          hazard;
  logic          issue;
  logic          set_en, clr_en;
  logic [31:0]   set_vec, clr_vec;

  // Stall detection from registered scoreboard only (no writeback bypass).
  always_comb begin
    hazard = 1'b0;
    if (id_rs1 != 5'd0 && pending_q[id_rs1]) hazard = 1'b1;
    if (id_rs2 != 5'd0 && pending_q[id_rs2]) hazard = 1'b1;
    if (id_rd  != 5'd0 && pending_q[id_rd])  hazard = 1'b1;
    if (id_long && id_rd != 5'd0 && count_q == MAX_CNT) hazard = 1'b1;
  end

  // Decoder/execute handshake outputs; forced low while reset is asserted.
  always_comb begin
    ex_valid = 1'b0;
    id_ready = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (id_valid && !id_flush) begin
            ex_valid = ~hazard;
            id_ready = ex_ready & ~hazard;
          end
        end
        ST_REQ:  id_ready = flush_ack;
        default: ;
      endcase
    end
  end

  // Scoreboard update: issued long op sets its rd, writeback clears its rd.
  always_comb begin
    issue   = ex_valid & ex_ready;
    set_en  = issue & id_long & (id_rd != 5'd0);
    clr_en  = wb_valid & (wb_rd != 5'd0) & pending_q[wb_rd];
    set_vec = set_en ? (32'd1 << id_rd) : 32'd0;
    clr_vec = clr_en ? (32'd1 << wb_rd) : 32'd0;
    pending_d = (pending_q & ~clr_vec) | set_vec;
    count_d   = count_q + CW'(set_en) - CW'(clr_en);
  end

  // FENCE.I sequencing: wait for scoreboard to empty, then request a flush.
  always_comb begin
    state_d     = state_q;
    flush_req_d = flush_req_q;
    case (state_q)
      ST_IDLE: begin
        if (id_valid && id_flush) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pending_q == 32'd0) begin
          state_d     = ST_REQ;
          flush_req_d = 1'b1;
        end
      end
      ST_REQ: begin
        if (flush_ack) begin
          state_d     = ST_IDLE;
          flush_req_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        flush_req_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset; reset forgets outstanding ops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pending_q   <= 32'd0;
      count_q     <= '0;
      flush_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      count_q     <= count_d;
      flush_req_q <= flush_req_d;
    end
  end

  assign flush_req = flush_req_q;
  assign pending   = pending_q;
  assign busy      = (state_q != ST_IDLE) | (pending_q != 32'd0);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: per-cycle vector table plus hand sequences
// for reset and the FENCE.I drain/flush handshake.
module tb_issue_ctrl;

  logic        clock;
  logic        reset;
  logic        id_valid;
  logic        id_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_long;
  logic        id_flush;
  logic        ex_valid;
  logic        ex_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush_req;
  logic        flush_ack;
  logic [31:0] pending;
  logic        busy;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  issue_ctrl #(.MAX_OUTSTANDING(4)) dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_long(id_long), .id_flush(id_flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush_req(flush_req), .flush_ack(flush_ack),
    .pending(pending), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        v;
    logic [4:0]  rs1, rs2, rd;
    logic        lng, exr, wbv;
    logic [4:0]  wbrd;
    logic        exp_exv, exp_idr;
    logic [31:0] exp_pend;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, logic lng, logic exr, logic wbv,
                              logic [4:0] wbrd, logic exv, logic idr,
                              logic [31:0] pend, logic bsy);
    vec_t r;
    r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.lng = lng; r.exr = exr;
    r.wbv = wbv; r.wbrd = wbrd; r.exp_exv = exv; r.exp_idr = idr;
    r.exp_pend = pend; r.exp_busy = bsy;
    return r;
  endfunction

  // Driver tasks.
  task automatic set_in(logic v, logic [4:0] rs1, logic [4:0] rs2,
                        logic [4:0] rd, logic lng, logic fl, logic exr,
                        logic wbv, logic [4:0] wbrd, logic ack);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_long = lng;
    id_flush = fl; ex_ready = exr; wb_valid = wbv; wb_rd = wbrd;
    flush_ack = ack;
  endtask

  task automatic idle_in();
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard compare.
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: act=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  initial begin
    // Table: one entry per cycle; pending/busy are the values seen that cycle.
    // Load x5 then dependent add, wb in the third stall cycle.
    vecs.push_back(mk(1, 0, 0,  5, 1, 1, 0, 0, 1, 1, 32'h0,   0));
    vecs.push_back(mk(1, 5, 1,  6, 0, 1, 0, 0, 0, 0, 32'h20,  1));
    vecs.push_back(mk(1, 5, 1,  6, 0, 1, 0, 0, 0, 0, 32'h20,  1));
    vecs.push_back(mk(1, 5, 1,  6, 0, 1, 1, 5, 0, 0, 32'h20,  1));
    vecs.push_back(mk(1, 5, 1,  6, 0, 1, 0, 0, 1, 1, 32'h0,   0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 32'h0,   0));
    // Downstream not ready: valid offered, nothing consumed or tracked.
    vecs.push_back(mk(1, 0, 0, 10, 1, 0, 0, 0, 1, 0, 32'h0,   0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 32'h0,   0));
    // Fill to MAX_OUTSTANDING, fifth long stalls until wb x2.
    vecs.push_back(mk(1, 0, 0,  1, 1, 1, 0, 0, 1, 1, 32'h0,   0));
    vecs.push_back(mk(1, 0, 0,  2, 1, 1, 0, 0, 1, 1, 32'h2,   1));
    vecs.push_back(mk(1, 0, 0,  3, 1, 1, 0, 0, 1, 1, 32'h6,   1));
    vecs.push_back(mk(1, 0, 0,  4, 1, 1, 0, 0, 1, 1, 32'hE,   1));
    vecs.push_back(mk(1, 0, 0,  7, 1, 1, 0, 0, 0, 0, 32'h1E,  1));
    vecs.push_back(mk(1, 0, 0,  7, 1, 1, 1, 2, 0, 0, 32'h1E,  1));
    vecs.push_back(mk(1, 0, 0,  7, 1, 1, 0, 0, 1, 1, 32'h1A,  1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 1, 1, 0, 0, 32'h9A,  1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 1, 3, 0, 0, 32'h98,  1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 1, 4, 0, 0, 32'h90,  1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 1, 7, 0, 0, 32'h80,  1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 1, 12, 0, 0, 32'h0,  0));
    // rs2 hazard; short op with rd!=0 is not tracked.
    vecs.push_back(mk(1, 0, 0,  6, 1, 1, 0, 0, 1, 1, 32'h0,   0));
    vecs.push_back(mk(1, 0, 6, 11, 0, 1, 0, 0, 0, 0, 32'h40,  1));
    vecs.push_back(mk(1, 0, 6, 11, 0, 1, 1, 6, 0, 0, 32'h40,  1));
    vecs.push_back(mk(1, 0, 6, 11, 0, 1, 0, 0, 1, 1, 32'h0,   0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 1, 0, 0, 0, 32'h0,   0));
    // WAW on x3; long op to x0 issues untracked.
    vecs.push_back(mk(1, 0, 0,  3, 1, 1, 0, 0, 1, 1, 32'h0,   0));
    vecs.push_back(mk(1, 0, 0,  3, 1, 1, 0, 0, 0, 0, 32'h8,   1));
    vecs.push_back(mk(1, 0, 0,  0, 1, 1, 0, 0, 1, 1, 32'h8,   1));
    vecs.push_back(mk(1, 0, 0,  3, 1, 1, 1, 3, 0, 0, 32'h8,   1));
    vecs.push_back(mk(1, 0, 0,  3, 1, 1, 0, 0, 1, 1, 32'h0,   0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 32'h8,   1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 1, 3, 0, 0, 32'h8,   1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 32'h0,   0));
    // Same-cycle issue x8 and wb x5; count stays 1, so 4th extra long stalls.
    vecs.push_back(mk(1, 0, 0,  5, 1, 1, 0, 0, 1, 1, 32'h0,   0));
    vecs.push_back(mk(1, 0, 0,  8, 1, 1, 1, 5, 1, 1, 32'h20,  1));
    vecs.push_back(mk(1, 0, 0,  1, 1, 1, 0, 0, 1, 1, 32'h100, 1));
    vecs.push_back(mk(1, 0, 0,  2, 1, 1, 0, 0, 1, 1, 32'h102, 1));
    vecs.push_back(mk(1, 0, 0,  3, 1, 1, 0, 0, 1, 1, 32'h106, 1));
    vecs.push_back(mk(1, 0, 0,  4, 1, 1, 0, 0, 0, 0, 32'h10E, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 1, 1, 0, 0, 32'h10E, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 1, 2, 0, 0, 32'h10C, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 1, 3, 0, 0, 32'h108, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 1, 8, 0, 0, 32'h100, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 32'h0,   0));

    // Reset with an instruction offered: handshake outputs must stay low.
    reset = 1'b1;
    set_in(1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    sample();
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_id_ready", {31'd0, id_ready}, 32'd0);
    next_cycle();
    sample();
    next_cycle();
    reset = 1'b0;
    idle_in();
    sample();
    chk("rst_pending", pending, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_flush_req", {31'd0, flush_req}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    next_cycle();

    // Vector table.
    for (int i = 0; i < vecs.size(); i++) begin
      set_in(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].lng,
             1'b0, vecs[i].exr, vecs[i].wbv, vecs[i].wbrd, 1'b0);
      sample();
      chk($sformatf("v%0d_ex_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].exp_exv});
      chk($sformatf("v%0d_id_ready", i), {31'd0, id_ready}, {31'd0, vecs[i].exp_idr});
      chk($sformatf("v%0d_pending", i), pending, vecs[i].exp_pend);
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
      next_cycle();
    end

    // FENCE.I with x9 outstanding.
    set_in(1, 0, 0, 9, 1, 0, 1, 0, 0, 0);
    sample();
    chk("f_issue_x9", {31'd0, ex_valid}, 32'd1);
    next_cycle();
    set_in(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    sample();
    chk("f_fence_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("f_fence_id_ready", {31'd0, id_ready}, 32'd0);
    next_cycle();
    set_in(1, 0, 0, 0, 0, 1, 1, 0, 0, 1);  // stray ack while draining
    sample();
    chk("f_drain_flush_req", {31'd0, flush_req}, 32'd0);
    chk("f_drain_id_ready", {31'd0, id_ready}, 32'd0);
    chk("f_drain_busy", {31'd0, busy}, 32'd1);
    chk("f_drain_pending", pending, 32'h200);
    next_cycle();
    set_in(1, 0, 0, 0, 0, 1, 1, 1, 9, 0);
    sample();
    chk("f_wb_flush_req", {31'd0, flush_req}, 32'd0);
    chk("f_wb_id_ready", {31'd0, id_ready}, 32'd0);
    next_cycle();
    set_in(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    sample();
    chk("f_after_wb_pending", pending, 32'd0);
    chk("f_after_wb_ex_valid", {31'd0, ex_valid}, 32'd0);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      sample();
      chk($sformatf("f_req%0d_flush_req", k), {31'd0, flush_req}, 32'd1);
      chk($sformatf("f_req%0d_id_ready", k), {31'd0, id_ready}, 32'd0);
      next_cycle();
    end
    set_in(1, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    sample();
    chk("f_ack_id_ready", {31'd0, id_ready}, 32'd1);
    chk("f_ack_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("f_ack_flush_req", {31'd0, flush_req}, 32'd1);
    next_cycle();
    idle_in();
    sample();
    chk("f_done_flush_req", {31'd0, flush_req}, 32'd0);
    chk("f_done_busy", {31'd0, busy}, 32'd0);
    chk("f_done_state", {30'd0, dbg_state}, 32'd0);
    next_cycle();
    // Back in IDLE, normal issue resumes.
    set_in(1, 0, 0, 13, 0, 0, 1, 0, 0, 0);
    sample();
    chk("f_resume_id_ready", {31'd0, id_ready}, 32'd1);
    next_cycle();

    // Reset while draining with x4 outstanding; later wb x4 ignored.
    set_in(1, 0, 0, 4, 1, 0, 1, 0, 0, 0);
    next_cycle();
    set_in(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    next_cycle();
    sample();
    chk("rd_busy", {31'd0, busy}, 32'd1);
    chk("rd_pending", pending, 32'h10);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    idle_in();
    sample();
    chk("rd_after_flush_req", {31'd0, flush_req}, 32'd0);
    chk("rd_after_busy", {31'd0, busy}, 32'd0);
    chk("rd_after_pending", pending, 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 4, 0);
    next_cycle();
    idle_in();
    sample();
    chk("rd_wb_pending", pending, 32'd0);
    chk("rd_wb_busy", {31'd0, busy}, 32'd0);
    next_cycle();

    // Reset while in REQ.
    set_in(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    next_cycle();
    next_cycle();
    sample();
    chk("rr_flush_req", {31'd0, flush_req}, 32'd1);
    reset = 1'b1;
    set_in(1, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    sample();
    chk("rr_rst_id_ready", {31'd0, id_ready}, 32'd0);
    next_cycle();
    reset = 1'b0;
    idle_in();
    sample();
    chk("rr_after_flush_req", {31'd0, flush_req}, 32'd0);
    chk("rr_after_busy", {31'd0, busy}, 32'd0);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
